llc_cache: RTL and testbench

//  Direct-mapped, write-back, write-allocate last-level cache between the CPU data/instr port
//  and cacheline_adaptor. Serves 32-bit word accesses on hit and issues 256-bit line

---
 rtl/llc_cache_pkg.sv | 33 +++
 rtl/llc_cache_ctrl.sv | 82 ++++++++
 rtl/llc_cache.sv | 151 +++++++++++++++
 tb/tb_llc_cache.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_cache_pkg.sv
// Shared types and address helpers for the direct-mapped last-level cache.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package llc_cache_pkg;

    localparam int S_OFFSET = 5;        // 32-byte (256-bit) lines
    localparam int LINE_W   = 256;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        WB      = 2'd2,
        FILL    = 2'd3
    } state_t;

    // Tag field, right-aligned; callers keep the low 32-S_INDEX-S_OFFSET bits.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int s_index);
        return addr >> (S_OFFSET + s_index);
    endfunction

    // Set index, right-aligned; callers keep the low s_index bits.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int s_index);
        return (addr >> S_OFFSET) & ((32'd1 << s_index) - 32'd1);
    endfunction

    // 32-bit word select within the line.
    function automatic logic [2:0] addr_word(input logic [31:0] addr);
        return addr[4:2];
    endfunction

endpackage

// File: rtl/llc_cache_ctrl.sv
// Cache controller FSM: sequences compare, victim writeback and line fill.
// Latency: hit completes in COMPARE (2 edges); miss adds the WB and FILL waits plus a re-compare.
// Backpressure: holds pmem_read/pmem_write until pmem_resp; the CPU holds its request until mem_resp.
// Ports: clk/rst; CPU request (mem_read, mem_write) and lookup results (hit, victim_dirty);
//        pmem_resp from downstream; state, handshake outputs, array write enables, perf strobes.
module llc_cache_ctrl
    import llc_cache_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   mem_read,
    input  logic   mem_write,
    input  logic   hit,
    input  logic   victim_dirty,
    input  logic   pmem_resp,
    output state_t state,
    output logic   mem_resp,
    output logic   pmem_read,
    output logic   pmem_write,
    output logic   word_we,
    output logic   line_load,
    output logic   cnt_hit,
    output logic   cnt_miss
);

    state_t state_n;
    // Set when COMPARE was entered from FILL: that compare is the re-check of
    // an already-counted request and must not touch the perf counters.
    logic   refill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            refill <= 1'b0;
        end else begin
            state  <= state_n;
            refill <= (state == FILL);
        end
    end

    always_comb begin
        state_n    = state;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        word_we    = 1'b0;
        line_load  = 1'b0;
        cnt_hit    = 1'b0;
        cnt_miss   = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_read || mem_write) state_n = COMPARE;
            end
            COMPARE: begin
                cnt_hit  = hit && !refill;
                cnt_miss = !hit && !refill;
                if (hit) begin
                    mem_resp = 1'b1;
                    word_we  = mem_write;
                    state_n  = IDLE;
                end else if (victim_dirty) begin
                    state_n = WB;
                end else begin
                    state_n = FILL;
                end
            end
            WB: begin
                pmem_write = 1'b1;
                if (pmem_resp) state_n = FILL;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    line_load = 1'b1;
                    state_n   = COMPARE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/llc_cache.sv
// Direct-mapped write-back/write-allocate LLC: 32-bit CPU words, 256-bit line traffic downstream.
// Latency: hit 2 edges; miss 2 + writeback wait + fill wait + 1 re-compare.
// Backpressure: CPU request held until mem_resp; pmem requests held until pmem_resp.
// Ports: clk, rst (sync, active high); CPU side mem_address/mem_read/mem_write/mem_byte_enable/
//        mem_wdata -> mem_rdata/mem_resp; line side pmem_address/pmem_read/pmem_write/pmem_wdata
//        <- pmem_rdata/pmem_resp; perf_hits/perf_misses.
// Optional build macro LLC_PERF_CNT_EN: enables the hit/miss counters; otherwise both read 0.
module llc_cache
    import llc_cache_pkg::*;
#(
    parameter int S_INDEX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic [31:0] pmem_address,
    output logic        pmem_read,
    output logic        pmem_write,
    output line_t       pmem_wdata,
    input  line_t       pmem_rdata,
    input  logic        pmem_resp,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
);

    localparam int S_TAG = 32 - S_INDEX - S_OFFSET;
    localparam int SETS  = 1 << S_INDEX;

    logic [S_TAG-1:0] tag_arr  [SETS];
    line_t            data_arr [SETS];
    logic [SETS-1:0]  valid_arr;
    logic [SETS-1:0]  dirty_arr;

    logic [31:0]        tag_full;
    logic [31:0]        idx_full;
    logic [S_TAG-1:0]   req_tag;
    logic [S_INDEX-1:0] idx;
    logic [2:0]         word;
    logic [7:0]         word_lsb;
    logic [31:0]        cur_word;
    logic [31:0]        merged_word;
    logic               hit;
    logic               victim_dirty;

    state_t state;
    logic   word_we;
    logic   line_load;
    logic   cnt_hit;
    logic   cnt_miss;

    assign tag_full = addr_tag(mem_address, S_INDEX);
    assign idx_full = addr_index(mem_address, S_INDEX);
    assign req_tag  = tag_full[S_TAG-1:0];
    assign idx      = idx_full[S_INDEX-1:0];
    assign word     = addr_word(mem_address);
    assign word_lsb = {word, 5'b0};

    logic unused_addr_bits;
    assign unused_addr_bits = ^{tag_full[31:S_TAG], idx_full[31:S_INDEX]};

    assign hit          = valid_arr[idx] && (tag_arr[idx] == req_tag);
    assign victim_dirty = valid_arr[idx] && dirty_arr[idx];
    assign cur_word     = data_arr[idx][word_lsb +: 32];

    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) merged_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
        end
    end

    llc_cache_ctrl u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .hit          (hit),
        .victim_dirty (victim_dirty),
        .pmem_resp    (pmem_resp),
        .state        (state),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .word_we      (word_we),
        .line_load    (line_load),
        .cnt_hit      (cnt_hit),
        .cnt_miss     (cnt_miss)
    );

    // Tag and data storage carries no reset; valid gates every use of it.
    always_ff @(posedge clk) begin
        if (line_load) begin
            data_arr[idx] <= pmem_rdata;
            tag_arr[idx]  <= req_tag;
        end else if (word_we) begin
            data_arr[idx][word_lsb +: 32] <= merged_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_arr <= '0;
            dirty_arr <= '0;
        end else if (line_load) begin
            valid_arr[idx] <= 1'b1;
            dirty_arr[idx] <= 1'b0;
        end else if (word_we && (|mem_byte_enable)) begin
            dirty_arr[idx] <= 1'b1;
        end
    end

    // Outputs are zero outside the states that drive them, so IDLE/reset shows all-zero.
    assign mem_rdata  = mem_resp ? cur_word : 32'h0;
    assign pmem_wdata = (state == WB) ? data_arr[idx] : '0;

    always_comb begin
        pmem_address = 32'h0;
        if (state == WB)   pmem_address = {tag_arr[idx], idx, {S_OFFSET{1'b0}}};
        if (state == FILL) pmem_address = {req_tag, idx, {S_OFFSET{1'b0}}};
    end

`ifdef LLC_PERF_CNT_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= 32'h0;
            misses_q <= 32'h0;
        end else begin
            if (cnt_hit)  hits_q   <= hits_q + 32'd1;
            if (cnt_miss) misses_q <= misses_q + 32'd1;
        end
    end

    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
`else
    logic unused_cnt;
    assign unused_cnt  = cnt_hit ^ cnt_miss;
    assign perf_hits   = 32'h0;
    assign perf_misses = 32'h0;
`endif

endmodule

// File: tb/tb_llc_cache.sv
// Self-checking bench for llc_cache: directed cold-miss/hit/write/evict/reset cases, then random traffic.
// Reference: word-addressed memory view plus a per-set tag/valid/dirty table; a line-granular backing store.
// Responds to pmem requests after a random 0-3 cycle delay.
module tb_llc_cache;
    import llc_cache_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic [31:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    line_t       pmem_wdata;
    line_t       pmem_rdata;
    logic        pmem_resp;
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;

    llc_cache dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp),
        .perf_hits       (perf_hits),
        .perf_misses     (perf_misses)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_words [logic [29:0]];   // CPU-visible memory, by word address
    line_t       bmem      [logic [26:0]];   // downstream memory, by line address
    bit          ref_valid [8];
    bit          ref_dirty [8];
    logic [23:0] ref_tag   [8];
    int unsigned ref_hits   = 0;
    int unsigned ref_misses = 0;

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        logic [31:0] a;
        a = {wa, 2'b00};
        return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] ref_get(input logic [29:0] wa);
        if (ref_words.exists(wa)) return ref_words[wa];
        return init_word(wa);
    endfunction

    function automatic line_t bmem_get(input logic [26:0] la);
        line_t l;
        if (bmem.exists(la)) return bmem[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word({la, w[2:0]});
        return l;
    endfunction

    task automatic preset_word(input logic [31:0] addr, input logic [31:0] val);
        line_t l;
        l = bmem_get(addr[31:5]);
        l[addr[4:2]*32 +: 32] = val;
        bmem[addr[31:5]] = l;
        ref_words[addr[31:2]] = val;
    endtask

    // Reset loses dirty lines: the CPU view falls back to what memory holds.
    task automatic ref_reset();
        line_t l;
        for (int s = 0; s < 8; s++) begin
            if (ref_valid[s] && ref_dirty[s]) begin
                l = bmem_get({ref_tag[s], s[2:0]});
                for (int w = 0; w < 8; w++) ref_words[{ref_tag[s], s[2:0], w[2:0]}] = l[w*32 +: 32];
            end
            ref_valid[s] = 1'b0;
            ref_dirty[s] = 1'b0;
        end
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    task automatic check_perf();
`ifdef LLC_PERF_CNT_EN
        check("perf_hits", perf_hits, ref_hits);
        check("perf_misses", perf_misses, ref_misses);
`else
        check("perf_hits_tied", perf_hits, 32'h0);
        check("perf_misses_tied", perf_misses, 32'h0);
`endif
    endtask

    // ---------------- downstream memory ----------------
    bit          hold_resp = 1'b0;
    bit          busy      = 1'b0;
    int          dly       = 0;
    bit          saw_rd, saw_wr;
    logic [31:0] rd_addr_seen, wr_addr_seen;
    int          rd_dly, wr_dly;
    int          excl_err  = 0;

    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) excl_err++;
            if ((pmem_read || pmem_write) && !hold_resp) begin
                if (!busy) begin
                    busy = 1'b1;
                    dly  = int'($urandom_range(0, 3));
                    if (pmem_write) begin
                        saw_wr = 1'b1; wr_addr_seen = pmem_address; wr_dly = dly;
                    end else begin
                        saw_rd = 1'b1; rd_addr_seen = pmem_address; rd_dly = dly;
                    end
                end
                if (dly == 0) begin
                    if (pmem_write) bmem[pmem_address[31:5]] = pmem_wdata;
                    else            pmem_rdata = bmem_get(pmem_address[31:5]);
                    pmem_resp = 1'b1;
                    busy      = 1'b0;
                end else begin
                    dly--;
                end
            end else if (!(pmem_read || pmem_write)) begin
                busy = 1'b0;
            end
        end
    end

    // ---------------- CPU access ----------------
    logic [31:0] last_rdata;

    task automatic access(input logic [31:0] addr, input bit rd, input bit wr,
                          input logic [3:0] be, input logic [31:0] wd);
        logic [2:0]  set;
        logic [23:0] tg;
        bit          exp_hit, exp_wb, got;
        logic [31:0] victim, exp_rd, merged;
        int          n, exp_lat;
        set     = addr[7:5];
        tg      = addr[31:8];
        exp_hit = ref_valid[set] && (ref_tag[set] == tg);
        exp_wb  = !exp_hit && ref_valid[set] && ref_dirty[set];
        victim  = {ref_tag[set], set, 5'b0};
        exp_rd  = ref_get(addr[31:2]);

        @(negedge clk);
        saw_rd = 1'b0; saw_wr = 1'b0; excl_err = 0;
        mem_address = addr; mem_read = rd; mem_write = wr;
        mem_byte_enable = be; mem_wdata = wd;
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (mem_resp) got = 1'b1;
        end
        check("resp_seen", 32'(got), 32'd1);
        last_rdata = mem_rdata;
        if (got) begin
            if (rd && !wr) check("rdata", mem_rdata, exp_rd);
            exp_lat = exp_hit ? 2 : 3 + (exp_wb ? wr_dly + 1 : 0) + rd_dly + 1;
            check("latency", 32'(n + 1), 32'(exp_lat));
        end
        check("hit", 32'(!(saw_rd || saw_wr)), 32'(exp_hit));
        if (exp_wb) check("wb_addr", saw_wr ? wr_addr_seen : 32'hFFFF_FFFF, victim);
        else        check("no_wb", 32'(saw_wr), 32'd0);
        if (!exp_hit) check("fill_addr", saw_rd ? rd_addr_seen : 32'hFFFF_FFFF, {addr[31:5], 5'b0});
        check("pmem_excl", 32'(excl_err), 32'd0);
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;

        if (exp_hit) ref_hits++;
        else begin
            ref_misses++;
            ref_valid[set] = 1'b1;
            ref_tag[set]   = tg;
            ref_dirty[set] = 1'b0;
        end
        if (wr) begin
            merged = ref_get(addr[31:2]);
            for (int b = 0; b < 4; b++) if (be[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
            ref_words[addr[31:2]] = merged;
            if (|be) ref_dirty[set] = 1'b1;
        end
        check_perf();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] orig, t3_exp, a;
        logic [23:0] rtag;
        logic [2:0]  rset, rword;
        line_t       l;
        int          op, n;

        rst = 1'b1;
        mem_address = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = 4'h0; mem_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_resp", 32'(mem_resp), 32'd0);
        check("rst_pmem_read", 32'(pmem_read), 32'd0);
        check("rst_pmem_write", 32'(pmem_write), 32'd0);
        check("rst_pmem_address", pmem_address, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_pmem_wdata_zero", 32'(|pmem_wdata), 32'd0);
        check_perf();
        @(negedge clk);
        rst = 1'b0;

        // 1: cold read miss fills line 0x1000
        preset_word(32'h0000_1004, 32'hDEAD_BEEF);
        access(32'h0000_1004, 1'b1, 1'b0, 4'h0, 32'h0);
        check("t1_rdata", last_rdata, 32'hDEAD_BEEF);
        // 2: re-read hits in 2 edges
        access(32'h0000_1004, 1'b1, 1'b0, 4'h0, 32'h0);
        // 3: partial write hit, then read back merged word
        access(32'h0000_1008, 1'b0, 1'b1, 4'b0011, 32'h1234_5678);
        access(32'h0000_1008, 1'b1, 1'b0, 4'h0, 32'h0);
        orig   = init_word(30'(32'h0000_1008 >> 2));
        t3_exp = {orig[31:16], 16'h5678};
        check("t3_merged", last_rdata, t3_exp);
        // 4: conflicting tag in set 0 evicts the dirty line
        access(32'h0000_1108, 1'b1, 1'b0, 4'h0, 32'h0);
        l = bmem_get(27'(32'h0000_1000 >> 5));
        check("t4_wb_word", l[2*32 +: 32], t3_exp);

        // 5: reset in the middle of a fill
        hold_resp = 1'b1;
        @(negedge clk);
        mem_address = 32'h0000_1004; mem_read = 1'b1;
        n = 0;
        while (!pmem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_fill_started", 32'(pmem_read), 32'd1);
        rst = 1'b1; mem_read = 1'b0;
        @(posedge clk);
        #1;
        check("t5_pmem_read_drop", 32'(pmem_read), 32'd0);
        check("t5_pmem_addr_zero", pmem_address, 32'h0);
        check("t5_mem_resp", 32'(mem_resp), 32'd0);
        @(negedge clk);
        rst = 1'b0; hold_resp = 1'b0;
        ref_reset();
        check_perf();
        access(32'h0000_1004, 1'b1, 1'b0, 4'h0, 32'h0);

        // random traffic over four tags to mix hits, clean and dirty conflicts
        for (int i = 0; i < 400; i++) begin
            rtag  = 24'h10 + 24'($urandom_range(0, 3));
            rset  = 3'($urandom_range(0, 7));
            rword = 3'($urandom_range(0, 7));
            a     = {rtag, rset, rword, 2'($urandom_range(0, 3))};
            op    = int'($urandom_range(0, 19));
            if (op < 11)      access(a, 1'b1, 1'b0, 4'h0, 32'h0);
            else if (op < 19) access(a, 1'b0, 1'b1, 4'($urandom_range(0, 15)), $urandom);
            else              access(a, 1'b1, 1'b1, 4'($urandom_range(0, 15)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
